// File: rtl/hiscore_ram_arbiter_pkg.sv
// Shared definitions for the hiscore RAM arbiter.
// Contents: FSM state encoding, default settle length, data width, and a small
//           max helper used to size the shared settle/timeout counter.
package arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PAUSE_WAIT,
      ST_SETTLE,
      ST_GRANT,
      ST_RELEASE
   } arb_state_t;

   localparam int SETTLE_CYC_DEF = 4;
   localparam int DATA_W         = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hiscore_ram_arbiter_if.sv
// Hiscore engine <-> arbiter handshake bundle.
// master: engine side (drives hs_req/hs_strobe/hs_we/hs_addr/hs_wdata).
// slave : arbiter side (drives hs_grant/hs_ack/hs_rdata/hs_timeout).
interface hiscore_ram_arbiter_if
   import arb_pkg::*;
#(
   parameter int ADDR_W = 16
) ();

   logic              hs_req;
   logic              hs_strobe;
   logic              hs_we;
   logic [ADDR_W-1:0] hs_addr;
   logic [DATA_W-1:0] hs_wdata;
   logic              hs_grant;
   logic              hs_ack;
   logic [DATA_W-1:0] hs_rdata;
   logic              hs_timeout;

   modport master (
      output hs_req, hs_strobe, hs_we, hs_addr, hs_wdata,
      input  hs_grant, hs_ack, hs_rdata, hs_timeout
   );

   modport slave (
      input  hs_req, hs_strobe, hs_we, hs_addr, hs_wdata,
      output hs_grant, hs_ack, hs_rdata, hs_timeout
   );

endinterface

// File: rtl/hiscore_ram_arbiter_timer.sv
// arb_timer: loadable down-counter that stops at zero.
// Ports: clk/rst (async active-high), load + load_val (load wins over count),
//        en (decrement while non-zero), zero (combinational count==0 flag).
module arb_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Arbitrates a shared synchronous RAM between the system CPU and a hiscore engine.
// Ports: clk_sys/reset (async active-high); hs = engine handshake (slave modport);
//        pause_req/cpu_paused CPU halt handshake; cpu_* CPU RAM bus; ram_* shared RAM.
module hiscore_ram_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int TIMEOUT_W  = 16
) (
   input  logic              clk_sys,
   input  logic              reset,
   hiscore_ram_arbiter_if.slave hs,
   output logic              pause_req,
   input  logic              cpu_paused,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   // One counter serves both the pause-wait timeout and the settle delay,
   // so it is sized for whichever needs more bits.
   localparam int CNT_W = max_int(TIMEOUT_W, $clog2(SETTLE_CYC + 1));
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'({TIMEOUT_W{1'b1}});
   // The cycle in which cpu_paused is first seen counts as the first settle
   // cycle and the counter's zero cycle as the last, so grant lands exactly
   // SETTLE_CYC cycles after the acknowledge.
   localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'((SETTLE_CYC >= 2) ? SETTLE_CYC - 2 : 0);

   arb_state_t        state;
   logic              grant_q;
   logic              pause_q;
   logic              ack_q;
   logic [DATA_W-1:0] rdata_q;
   logic              timeout_q;
   logic              armed_q;     // hs_req has been seen low since reset/timeout
   logic              acc_q;       // accepted access is driving the RAM this cycle
   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_we_q;
   logic [DATA_W-1:0] ram_wdata_q;

   logic              req_start;
   logic              accept;
   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic              tmr_en;
   logic              tmr_zero;
   logic              sel_hs;

   always_comb begin
      req_start = hs.hs_req && armed_q;
      accept    = (state == ST_GRANT) && cpu_paused && hs.hs_req &&
                  hs.hs_strobe && !acc_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      if ((state == ST_IDLE) && req_start) begin
         tmr_load = 1'b1;
         tmr_val  = TIMEOUT_LOAD;
      end else if ((state == ST_PAUSE_WAIT) && hs.hs_req && cpu_paused) begin
         tmr_load = 1'b1;
         tmr_val  = SETTLE_LOAD;
      end
      tmr_en = (state == ST_PAUSE_WAIT) || (state == ST_SETTLE);
   end

   arb_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk      (clk_sys),
      .rst      (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant_q     <= 1'b0;
         pause_q     <= 1'b0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         timeout_q   <= 1'b0;
         armed_q     <= 1'b0;
         acc_q       <= 1'b0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
      end else begin
         ack_q    <= 1'b0;
         ram_we_q <= 1'b0;
         acc_q    <= accept;
         if (accept) begin
            ram_addr_q  <= hs.hs_addr;
            ram_we_q    <= hs.hs_we;
            ram_wdata_q <= hs.hs_wdata;
         end
         if (ack_q) begin
            rdata_q <= ram_rdata;
         end
         if (!hs.hs_req) begin
            armed_q <= 1'b1;
         end
         if (req_start) begin
            timeout_q <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               pause_q <= 1'b0;
               grant_q <= 1'b0;
               if (req_start) begin
                  state   <= ST_PAUSE_WAIT;
                  pause_q <= 1'b1;
               end
            end
            ST_PAUSE_WAIT: begin
               if (!hs.hs_req) begin
                  state   <= ST_IDLE;
                  pause_q <= 1'b0;
               end else if (cpu_paused) begin
                  state <= ST_SETTLE;
               end else if (tmr_zero) begin
                  // Re-arm only after hs_req is seen low, so a held request
                  // does not retry the pause forever.
                  state     <= ST_IDLE;
                  pause_q   <= 1'b0;
                  timeout_q <= 1'b1;
                  armed_q   <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (!cpu_paused || !hs.hs_req) begin
                  state <= ST_RELEASE;
               end else if (tmr_zero) begin
                  state   <= ST_GRANT;
                  grant_q <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (!cpu_paused) begin
                  // CPU resumed under us: abandon any in-flight access silently.
                  state   <= ST_RELEASE;
                  grant_q <= 1'b0;
                  acc_q   <= 1'b0;
               end else begin
                  if (acc_q) begin
                     ack_q <= 1'b1;
                  end
                  if (!hs.hs_req && !acc_q) begin
                     state   <= ST_RELEASE;
                     grant_q <= 1'b0;
                  end
               end
            end
            ST_RELEASE: begin
               state   <= ST_IDLE;
               pause_q <= 1'b0;
               grant_q <= 1'b0;
            end
            default: begin
               state   <= ST_IDLE;
               pause_q <= 1'b0;
               grant_q <= 1'b0;
            end
         endcase
      end
   end

   // The engine owns the RAM bus while granted or while an access is in the
   // RAM stage; otherwise the CPU path is a straight combinational pass.
   assign sel_hs    = grant_q || acc_q;
   assign ram_addr  = sel_hs ? ram_addr_q  : cpu_addr;
   assign ram_we    = sel_hs ? ram_we_q    : cpu_we;
   assign ram_wdata = sel_hs ? ram_wdata_q : cpu_wdata;

   // RAM data arrives in the ack cycle itself; pass it through then and keep
   // the captured copy afterwards.
   assign hs.hs_rdata   = ack_q ? ram_rdata : rdata_q;
   assign hs.hs_ack     = ack_q;
   assign hs.hs_grant   = grant_q;
   assign hs.hs_timeout = timeout_q;
   assign pause_req     = pause_q;

endmodule
